// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: eight two-operand functions, DEPTH-stage valid/ready pipe.
// Optional LOGIC_UNIT_ZERO_FLAG_EN adds out_zero, carried alongside each beat.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic [CNT_W-1:0] txn_count
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] d;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    logic             z;
`endif
  } stage_t;

  logic [WIDTH-1:0] w_res;
  stage_t           w_in;
  logic [DEPTH-1:0] w_load;
  logic [DEPTH-1:0] r_vld;
  stage_t           r_stg [DEPTH];
  logic [CNT_W-1:0] r_cnt;

  always_comb begin
    w_res = '0;
    unique case (op)
      3'b000: w_res = A & B;
      3'b001: w_res = A | B;
      3'b010: w_res = A ^ B;
      3'b011: w_res = ~(A & B);
      3'b100: w_res = ~(A | B);
      3'b101: w_res = ~(A ^ B);
      3'b110: w_res = A & ~B;
      3'b111: w_res = A;
    endcase
  end

  always_comb begin
    w_in   = '0;
    w_in.d = w_res;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    w_in.z = ~|w_res;
`endif
  end

  // Load enables ripple back from out_ready; an empty stage always loads.
  always_comb begin : p_load
    logic l;
    w_load = '0;
    l = ~r_vld[DEPTH-1] | out_ready;
    w_load[DEPTH-1] = l;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      l = ~r_vld[k] | l;
      w_load[k] = l;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_stg[k] <= '0;
      end
    end else begin
      if (w_load[0]) begin
        r_vld[0] <= in_valid;
        if (in_valid) begin
          r_stg[0] <= w_in;
        end
      end
      // Data only moves with a valid beat so Y holds after out_valid drops.
      for (int k = 1; k < DEPTH; k++) begin
        if (w_load[k]) begin
          r_vld[k] <= r_vld[k-1];
          if (r_vld[k-1]) begin
            r_stg[k] <= r_stg[k-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (out_valid && out_ready && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_vld[DEPTH-1];
  assign Y         = r_stg[DEPTH-1].d;
  assign txn_count = r_cnt;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  assign out_zero  = r_stg[DEPTH-1].z;
`endif

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the team's 2-input combinational gate.
- Performs one of eight bitwise two-operand logic functions on WIDTH-bit operands A and B.
- Result passes through DEPTH register stages with valid/ready handshakes on input and output.
- Keeps a saturating count of completed results; sits between stimulus generators and checkers in gate-characterisation datapaths.

Parameters:
- WIDTH, 8: operand/result bit width (>=1).
- DEPTH, 2: number of pipeline register stages (>=1); sets the unstalled latency.
- CNT_W, 16: width of the completed-result counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- op  in  3  function select, sampled with A and B.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- Y  out  WIDTH  result.
- txn_count  out  CNT_W  number of results handed off (out_valid & out_ready), saturating.

Behaviour:
- One clock domain; reset is asynchronous and active-low: asserting rst_n=0 immediately clears all stage valid bits, stage data, Y, out_valid and txn_count to 0. in_ready reads 1 when reset is released.
- Op encoding, computed combinationally at stage 0 input:
  - 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR.
  - 110 A & ~B.
  - 111 pass A.
- Accept: a beat transfers when in_valid & in_ready at a rising edge. A, B and op are don't-care when in_valid=0.
- Pipeline: stage k holds {valid_k, data_k}. Stage k loads from stage k-1 (stage 0 loads from the input) when stage k is empty or stage k itself advances.
  - Stage DEPTH-1 advances when out_ready=1.
  - Bubbles collapse: an empty stage always loads.
- in_ready = ~valid_0 | advance_0. It is combinational from out_ready through the stage chain; no registered skid.
- Latency: a beat accepted at edge n shows on Y/out_valid after edge n+DEPTH-1. With out_ready held 1, throughput is one beat per cycle.
- Backpressure:
  - With out_ready=0, Y and out_valid hold stable until the handshake.
  - The pipe fills to exactly DEPTH beats, then in_ready drops to 0.
  - No beat is lost or duplicated.
- Ordering is strictly FIFO.
- Y equals data_{DEPTH-1} and is 0 before the first result. Y keeps its last value after out_valid falls.
- txn_count increments by 1 on each output handshake and saturates at all-ones with no wrap.
- Simultaneous events: with a full pipe, out_ready=1 and in_valid=1 in the same cycle, one beat leaves and one enters; occupancy is unchanged.
- Reset mid-operation drops all in-flight beats; txn_count returns to 0.
- op values are registered with the data, so changing op between beats never affects earlier beats.

Optional Feature:
- Macro LOGIC_UNIT_ZERO_FLAG_EN.
- When defined:
  - Extra output port out_zero (1 bit), asserted when the stage-0 result is all zeros.
  - The flag is carried through the pipe alongside its beat and is valid with out_valid.
  - Reset value 0.
- When undefined: the port and its registers are absent, and all other behaviour is identical.

Test Plan:
- Truth sweep, WIDTH=8, DEPTH=2, out_ready=1: A=8'hF0, B=8'hCC with op=0..7 on consecutive cycles -> Y sequence C0, FC, 3C, 3F, 03, C3, 30, F0, each 2 cycles after its accept. txn_count ends at 8.
- Backpressure: out_ready=0, push 3 beats -> in_ready falls after 2 accepts and Y/out_valid stay stable. Raising out_ready -> all 3 results delivered in order, with no gaps once the pipe restarts.
- Simultaneous push/pop with a full pipe and out_ready=in_valid=1 -> in_ready=1 every cycle and one result per cycle.
- Async reset while 2 beats are in flight: drop rst_n between edges -> out_valid, Y and txn_count are 0 immediately. After release, the next beat's result appears 2 cycles after accept.
- Saturation with CNT_W=2: 5 handshakes -> txn_count reads 1, 2, 3, 3, 3.
- With LOGIC_UNIT_ZERO_FLAG_EN: op=000, A=8'h0F, B=8'hF0 -> Y=00 and out_zero=1. The next beat, op=001 -> out_zero=0.
